// File: rtl/btb_pkg.sv
// Shared constants, index hash and response record for the BTB target path.
// No logic state; pure definitions.
// Not applicable (no handshake lives here).
package btb_pkg;

    localparam int BTB_ADDR_WIDTH = 8;
    localparam int BTB_DATA_WIDTH = 32;
    localparam int BTB_XLEN       = 32;

    // Lookup result as seen by the fetch unit.
    typedef struct packed {
        logic                      hit;
        logic [BTB_DATA_WIDTH-1:0] target;
    } btb_rsp_t;

    // Direct-mapped, tagless: word-aligned PC bits select the entry, aliasing accepted.
    function automatic logic [BTB_ADDR_WIDTH-1:0] btb_index(input logic [BTB_XLEN-1:0] pc);
        return pc[BTB_ADDR_WIDTH+1:2];
    endfunction

endpackage

// File: rtl/btb_target_array.sv
// Behavioural single-port 2^ADDR_WIDTH x DATA_WIDTH macro with registered inputs.
// Write commits one edge after it is presented; read data follows the registered address.
// Address register holds while deselected so dout0 stays stable across stalls.
module btb_target_array #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk0,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic                  r_csb;
    logic                  r_web;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_din;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Input registers; address/data only capture on a selected access.
    always_ff @(posedge clk0) begin
        r_csb <= csb0;
        if (!csb0) begin
            r_web  <= web0;
            r_addr <= addr0;
            r_din  <= din0;
        end
    end

    // Array write from the registered request.
    always_ff @(posedge clk0) begin
        if (!r_csb && !r_web) begin
            r_mem[r_addr] <= r_din;
        end
    end

    assign dout0 = r_mem[r_addr];

endmodule

// File: rtl/btb_valid_bits.sv
// Per-entry valid flags for the BTB, kept in flops beside the target SRAM.
// Set/flush take effect at the next edge; read port is combinational.
// No backpressure; set and flush are applied unconditionally, flush wins.
module btb_valid_bits #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_flush,
    input  logic                  i_set_vld,
    input  logic [ADDR_WIDTH-1:0] i_set_idx,
    input  logic [ADDR_WIDTH-1:0] i_rd_idx,
    output logic                  o_rd_vld
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DEPTH-1:0] r_valid;

    // Flush clears every entry in one edge; otherwise an accepted update marks its entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (i_flush) begin
            r_valid <= '0;
        end else if (i_set_vld) begin
            r_valid[i_set_idx] <= 1'b1;
        end
    end

    assign o_rd_vld = r_valid[i_rd_idx];

endmodule

// File: rtl/btb_sram_ctrl.sv
// Arbitrates BTB lookups and updates onto one SRAM RW port; flush > update > lookup.
// Lookup accepted at edge N gives rsp_valid/rsp_target during cycle N+1.
// A stalled response (rsp_valid && !rsp_ready) blocks both request ports and deselects the SRAM.
module btb_sram_ctrl
    import btb_pkg::*;
#(
    parameter int ADDR_WIDTH = BTB_ADDR_WIDTH,
    parameter int DATA_WIDTH = BTB_DATA_WIDTH,
    parameter int XLEN       = BTB_XLEN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  lk_valid,
    output logic                  lk_ready,
    input  logic [XLEN-1:0]       lk_pc,
    input  logic                  upd_valid,
    output logic                  upd_ready,
    input  logic [XLEN-1:0]       upd_pc,
    input  logic [DATA_WIDTH-1:0] upd_target,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_hit,
    output logic [DATA_WIDTH-1:0] rsp_target,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_PEND = 1'b1;

    logic                  r_state;
    logic                  r_hit;
    logic                  w_state_nxt;
    logic                  w_port_free;
    logic                  w_upd_acc;
    logic                  w_lk_acc;
    logic                  w_hit_rd;
    logic [ADDR_WIDTH-1:0] w_upd_idx;
    logic [ADDR_WIDTH-1:0] w_lk_idx;
    btb_rsp_t              w_rsp;

    assign w_upd_idx = btb_index(upd_pc);
    assign w_lk_idx  = btb_index(lk_pc);

    // The port is busy only while a response is held by the consumer; reset also idles it
    // so the macro sees no access while rst_n is low.
    assign w_port_free = rst_n && !((r_state == ST_PEND) && !rsp_ready);
    assign upd_ready   = w_port_free && !flush;
    assign lk_ready    = w_port_free && !flush && !upd_valid;
    assign w_upd_acc   = upd_valid && upd_ready;
    assign w_lk_acc    = lk_valid && lk_ready;

    btb_valid_bits #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_valid_bits (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_flush   (flush),
        .i_set_vld (w_upd_acc),
        .i_set_idx (w_upd_idx),
        .i_rd_idx  (w_lk_idx),
        .o_rd_vld  (w_hit_rd)
    );

    // SRAM request straight from the accept decision; the macro registers it.
    always_comb begin
        sram_csb0  = 1'b1;
        sram_web0  = 1'b1;
        sram_addr0 = '0;
        sram_din0  = '0;
        if (w_upd_acc) begin
            sram_csb0  = 1'b0;
            sram_web0  = 1'b0;
            sram_addr0 = w_upd_idx;
            sram_din0  = upd_target;
        end else if (w_lk_acc) begin
            sram_csb0  = 1'b0;
            sram_addr0 = w_lk_idx;
        end
    end

    // Response FSM: a new lookup refills PEND back-to-back; an unconsumed response stays put.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_lk_acc) w_state_nxt = ST_PEND;
            ST_PEND: if (rsp_ready && !w_lk_acc) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register; a response in flight at reset is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Hit flag sampled with the lookup; flush turns a pending hit into a miss.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit <= 1'b0;
        end else if (flush) begin
            r_hit <= 1'b0;
        end else if (w_lk_acc) begin
            r_hit <= w_hit_rd;
        end
    end

    assign w_rsp.hit    = r_hit;
    assign w_rsp.target = sram_dout0;

    assign rsp_valid  = (r_state == ST_PEND);
    assign rsp_hit    = w_rsp.hit;
    assign rsp_target = w_rsp.target;

endmodule
